// File: rtl/alu.sv
// Registered WIDTH-bit ALU for the execute stage: AND/OR/ADD/SUB/SLT plus the
// complemented-B logic ops. One-cycle latency; a single register bank holds result and flags.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [2:0]       Cmd,
    output logic [WIDTH-1:0] o_Res,
    output logic             o_Zero,
    output logic             o_Neg,
    output logic             o_Carry,
    output logic             o_Ovf
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        CMD_AND  = 3'b000,
        CMD_OR   = 3'b001,
        CMD_ADD  = 3'b010,
        CMD_RSV  = 3'b011,
        CMD_ANDN = 3'b100,
        CMD_ORN  = 3'b101,
        CMD_SUB  = 3'b110,
        CMD_SLT  = 3'b111
    } cmd_e;

    logic [WIDTH-1:0] b_n;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;

    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;
    logic             ovf_nxt;

    assign b_n      = ~i_B;
    assign sum_ext  = {1'b0, i_A} + {1'b0, i_B};
    // Subtract as A + ~B + 1 so the carry-out reads as "no borrow".
    assign diff_ext = {1'b0, i_A} + {1'b0, b_n} + {{WIDTH{1'b0}}, 1'b1};

    assign add_ovf = (i_A[MSB] == i_B[MSB]) && (sum_ext[MSB] != i_A[MSB]);
    assign sub_ovf = (i_A[MSB] != i_B[MSB]) && (diff_ext[MSB] != i_A[MSB]);
    // Difference sign corrected by overflow gives a signed compare valid at the extremes.
    assign slt     = diff_ext[MSB] ^ sub_ovf;

    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (cmd_e'(Cmd))
            CMD_AND:  res_nxt = i_A & i_B;
            CMD_OR:   res_nxt = i_A | i_B;
            CMD_ADD: begin
                res_nxt   = sum_ext[MSB:0];
                carry_nxt = sum_ext[WIDTH];
                ovf_nxt   = add_ovf;
            end
            CMD_RSV:  res_nxt = '0;
            CMD_ANDN: res_nxt = i_A & b_n;
            CMD_ORN:  res_nxt = i_A | b_n;
            CMD_SUB: begin
                res_nxt   = diff_ext[MSB:0];
                carry_nxt = diff_ext[WIDTH];
                ovf_nxt   = sub_ovf;
            end
            CMD_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, slt};
            default:  res_nxt = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_Res   <= '0;
            o_Zero  <= 1'b0;
            o_Neg   <= 1'b0;
            o_Carry <= 1'b0;
            o_Ovf   <= 1'b0;
        end else begin
            o_Res   <= res_nxt;
            o_Zero  <= (res_nxt == '0);
            o_Neg   <= res_nxt[MSB];
            o_Carry <= carry_nxt;
            o_Ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and flags, checked one edge after each issue.
module tb_alu;

    localparam int WIDTH = 32;

    logic             i_clk;
    logic             i_rst_n;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic [2:0]       Cmd;
    logic [WIDTH-1:0] o_Res;
    logic             o_Zero;
    logic             o_Neg;
    logic             o_Carry;
    logic             o_Ovf;

    int n_vec  = 0;
    int n_miss = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_A     (i_A),
        .i_B     (i_B),
        .Cmd     (Cmd),
        .o_Res   (o_Res),
        .o_Zero  (o_Zero),
        .o_Neg   (o_Neg),
        .o_Carry (o_Carry),
        .o_Ovf   (o_Ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Compare {res, zero, neg, carry, ovf} against the expected packed value.
    task automatic check(input string tag, input logic [WIDTH-1:0] res,
                         input logic z, input logic n, input logic c, input logic v);
        logic [WIDTH+3:0] obs;
        logic [WIDTH+3:0] exp;
        obs = {o_Res, o_Zero, o_Neg, o_Carry, o_Ovf};
        exp = {res, z, n, c, v};
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: got res=%h z%0b n%0b c%0b v%0b, want res=%h z%0b n%0b c%0b v%0b",
                   tag, o_Res, o_Zero, o_Neg, o_Carry, o_Ovf, res, z, n, c, v);
        end
    endtask

    // Issue one op, step one edge, sample 1 time unit later.
    task automatic op(input string tag, input logic [2:0] c_in,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] res, input logic z, input logic n,
                      input logic c, input logic v);
        Cmd = c_in;
        i_A = a;
        i_B = b;
        @(posedge i_clk);
        #1;
        check(tag, res, z, n, c, v);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_A = '0;
        i_B = '0;
        Cmd = 3'b000;
        #1;
        check("reset_initial", 32'h0, 0, 0, 0, 0);
        @(posedge i_clk);
        #1;
        check("reset_ignores_edge", 32'h0, 0, 0, 0, 0);

        // Get nonzero outputs, then hit reset mid-cycle.
        @(negedge i_clk);
        i_rst_n = 1'b1;
        op("pre_reset_add", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1, 1, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("reset_async", 32'h0, 0, 0, 0, 0);
        Cmd = 3'b001; i_A = 32'h1; i_B = 32'h0;
        @(posedge i_clk);
        #1;
        check("reset_hold", 32'h0, 0, 0, 0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        op("and_1_0", 3'b000, 32'h1, 32'h0, 32'h0, 1, 0, 0, 0);
        op("and_1_1", 3'b000, 32'h1, 32'h1, 32'h1, 0, 0, 0, 0);

        op("or_0_0", 3'b001, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
        op("or_1_0", 3'b001, 32'h1, 32'h0, 32'h1, 0, 0, 0, 0);
        op("or_0_1", 3'b001, 32'h0, 32'h1, 32'h1, 0, 0, 0, 0);

        op("andn_1_1", 3'b100, 32'h1, 32'h1, 32'h0, 1, 0, 0, 0);
        op("andn_1_0", 3'b100, 32'h1, 32'h0, 32'h1, 0, 0, 0, 0);
        op("orn_0_1", 3'b101, 32'h0, 32'h1, 32'hFFFF_FFFE, 0, 1, 0, 0);

        op("add_1_2", 3'b010, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0);
        op("add_2_2", 3'b010, 32'h2, 32'h2, 32'h4, 0, 0, 0, 0);
        op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 1, 0);
        op("add_ovf_pos", 3'b010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 1);
        op("add_ovf_neg", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 0, 1, 1);

        op("sub_8_4", 3'b110, 32'h8, 32'h4, 32'h4, 0, 0, 1, 0);
        op("sub_5_2", 3'b110, 32'h5, 32'h2, 32'h3, 0, 0, 1, 0);
        op("sub_2_5", 3'b110, 32'h2, 32'h5, 32'hFFFF_FFFD, 0, 1, 0, 0);
        op("sub_ovf", 3'b110, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 0, 1, 1);
        op("sub_0_0", 3'b110, 32'h0, 32'h0, 32'h0, 1, 0, 1, 0);

        op("slt_1_5_a", 3'b111, 32'h1, 32'h5, 32'h1, 0, 0, 0, 0);
        op("slt_1_5_b", 3'b111, 32'h1, 32'h5, 32'h1, 0, 0, 0, 0);
        op("slt_5_1", 3'b111, 32'h5, 32'h1, 32'h0, 1, 0, 0, 0);
        op("slt_min_1", 3'b111, 32'h8000_0000, 32'h1, 32'h1, 0, 0, 0, 0);
        op("slt_max_m1", 3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0);

        op("rsv_a", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1, 0, 0, 0);
        op("rsv_b", 3'b011, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 0);

        // Inputs changing between edges must not disturb the registered outputs.
        op("hold_base", 3'b010, 32'h10, 32'h20, 32'h30, 0, 0, 0, 0);
        Cmd = 3'b110; i_A = 32'h0; i_B = 32'h1;
        #3;
        check("hold_mid_cycle", 32'h30, 0, 0, 0, 0);
        @(posedge i_clk);
        #1;
        check("hold_next_edge", 32'hFFFF_FFFF, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit arithmetic/logic unit for the datapath execute stage. It takes two operands and a 3-bit command and produces a result plus four status flags. All outputs are updated on the rising clock edge, one cycle after the operands are applied. The block is a pure function of the inputs sampled at each edge and keeps no other state.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2).
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_A  input  WIDTH  operand A.
- i_B  input  WIDTH  operand B.
- Cmd  input  3  operation select.
- o_Res  output  WIDTH  registered result.
- o_Zero  output  1  registered; 1 when the result is all zeros.
- o_Neg  output  1  registered; result MSB.
- o_Carry  output  1  registered; carry-out (add/sub only).
- o_Ovf  output  1  registered; signed overflow (add/sub only).

One clock; reset is asynchronous and active-low.

## Operation
Command encoding (Bm = bitwise NOT of B):
- 000: A AND B.
- 001: A OR B.
- 010: A + B, modulo 2^WIDTH.
  - o_Carry = carry out of the MSB.
  - o_Ovf = operands share a sign and the result sign differs.
- 011: reserved. Result is 0, o_Zero=1, all other flags 0.
- 100: A AND Bm.
- 101: A OR Bm.
- 110: A − B, computed as A + Bm + 1, modulo 2^WIDTH.
  - o_Carry = carry out of that sum, i.e. 1 when A ≥ B unsigned (no borrow).
  - o_Ovf = A and B differ in sign and the result sign differs from A.
- 111: set-less-than, signed.
  - Result = 1 (zero-extended) when A < B as two's-complement, else 0.
  - Derived from the A−B sign XOR subtract overflow, so it is correct at all extremes.

Flag rules:
- o_Zero and o_Neg are computed from the final result for every command.
- o_Carry and o_Ovf are 0 for every command except 010 and 110.

General:
- No X propagation: every Cmd value drives a defined result.
- Combinational next-state logic feeds a single register bank holding o_Res and the four flags.

## Timing
- Latency is 1 cycle. Inputs present before rising edge N appear on the outputs after edge N and hold until edge N+1.
- No handshake. A new operation can be issued every cycle; throughput is one result per clock.
- i_rst_n low immediately forces o_Res=0, o_Zero=0, o_Neg=0, o_Carry=0, o_Ovf=0, independent of the clock.
- While i_rst_n is low, edges are ignored.
- On the first rising edge after i_rst_n rises, the inputs present at that edge are captured normally.
- If reset asserts mid-stream, the in-flight result is discarded. There is no recovery or replay.
- Input changes between edges have no effect on the outputs.

## Test plan
- Reset and logic:
  - Assert i_rst_n low mid-cycle; all outputs must go to 0 immediately.
  - Release reset, then Cmd=000 with A=1,B=0 → o_Res=0, o_Zero=1.
  - Next cycle Cmd=000 with A=1,B=1 → o_Res=1.
- OR and complement ops:
  - Cmd=001: (0,0) → 0; (1,0) → 1; (0,1) → 1.
  - Cmd=100: A=1,B=1 → 0 and A=1,B=0 → 1.
  - Cmd=101: A=0,B=1 → 0xFFFFFFFE, o_Neg=1.
- Add:
  - Cmd=010: A=1,B=2 → 3; A=2,B=2 → 4.
  - A=0xFFFFFFFF,B=1 → 0 with o_Carry=1, o_Zero=1, o_Ovf=0.
  - A=0x7FFFFFFF,B=1 → 0x80000000 with o_Ovf=1, o_Neg=1.
- Subtract:
  - Cmd=110: A=8,B=4 → 4, o_Carry=1; A=5,B=2 → 3.
  - A=2,B=5 → 0xFFFFFFFD, o_Carry=0, o_Neg=1.
  - A=0x80000000,B=1 → 0x7FFFFFFF, o_Ovf=1.
- Set-less-than:
  - Cmd=111: A=1,B=5 → 1; hold for two cycles and the output must stay 1.
  - A=5,B=1 → 0.
  - A=0x80000000,B=1 → 1; A=0x7FFFFFFF,B=0xFFFFFFFF → 0.
- Latency and reserved command:
  - Back-to-back commands every cycle; each result must appear exactly one edge after its inputs.
  - Cmd=011 with any operands → o_Res=0, o_Zero=1, other flags 0.
